// File: rtl/ps2_game_input_if.sv
// Byte-in / control-out bundle between the PS/2 receiver,
// the key translator and the game renderer.
interface ps2_game_input_if;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       move_left;
  logic       move_right;
  logic       fire;
  logic       pause;

  modport master (
    output ps2_data,
    output ps2_valid,
    input  move_left,
    input  move_right,
    input  fire,
    input  pause
  );

  modport slave (
    input  ps2_data,
    input  ps2_valid,
    output move_left,
    output move_right,
    output fire,
    output pause
  );
endinterface

// File: rtl/ps2_game_input.sv
// PS/2 scan-code translator: make/break/extended tracking,
// held-key flags, rate-limited fire and toggling pause.
module ps2_game_input #(
  parameter int FIRE_COOLDOWN = 2500000,
  parameter int CNT_W         = 22
) (
  input logic             iVGA_CLK,
  input logic             iRST_n,
  ps2_game_input_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK
  } state_t;

  state_t     state_q, state_d;
  logic       a_held_q, a_held_d;
  logic       d_held_q, d_held_d;
  logic       la_held_q, la_held_d;
  logic       ra_held_q, ra_held_d;
  logic       sp_held_q, sp_held_d;
  logic       p_held_q, p_held_d;
  logic       pause_st_q, pause_st_d;
  logic       move_left_q, move_left_d;
  logic       move_right_q, move_right_d;
  logic       fire_q, fire_d;
  logic       pause_q, pause_d;
  logic [CNT_W-1:0] cd_q, cd_d;

  logic mk, bk, ext, l_any, r_any;
  logic is_e0, is_f0;

  assign is_e0 = bus.ps2_data == 8'hE0;
  assign is_f0 = bus.ps2_data == 8'hF0;

  always_comb begin
    state_d    = state_q;
    a_held_d   = a_held_q;
    d_held_d   = d_held_q;
    la_held_d  = la_held_q;
    ra_held_d  = ra_held_q;
    sp_held_d  = sp_held_q;
    p_held_d   = p_held_q;
    pause_st_d = pause_st_q;
    mk  = 1'b0;
    bk  = 1'b0;
    ext = 1'b0;
    if (bus.ps2_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_e0)      state_d = S_EXT;
          else if (is_f0) state_d = S_BRK;
          else            mk = 1'b1;
        end
        S_EXT: begin
          if (is_f0) state_d = S_EXT_BRK;
          else if (!is_e0) begin
            mk = 1'b1; ext = 1'b1; state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (is_e0) state_d = S_EXT_BRK;
          else if (!is_f0) begin
            bk = 1'b1; state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (!is_e0 && !is_f0) begin
            bk = 1'b1; ext = 1'b1; state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if ((mk || bk) && !ext) begin
      case (bus.ps2_data)
        8'h1C: a_held_d  = mk;
        8'h23: d_held_d  = mk;
        8'h29: sp_held_d = mk;
        8'h4D: begin
          // only a fresh press toggles; typematic repeats do not
          if (mk && !p_held_q) pause_st_d = ~pause_st_q;
          p_held_d = mk;
        end
        default: ;
      endcase
    end
    if ((mk || bk) && ext) begin
      case (bus.ps2_data)
        8'h6B:   la_held_d = mk;
        8'h74:   ra_held_d = mk;
        default: ;
      endcase
    end

    l_any        = a_held_q | la_held_q;
    r_any        = d_held_q | ra_held_q;
    move_left_d  = l_any & ~r_any & ~pause_st_q;
    move_right_d = r_any & ~l_any & ~pause_st_q;
    pause_d      = pause_st_q;
    fire_d       = sp_held_q & (cd_q == '0) & ~pause_st_q;
    if (fire_d)          cd_d = CNT_W'(FIRE_COOLDOWN);
    else if (cd_q != '0) cd_d = cd_q - CNT_W'(1);
    else                 cd_d = cd_q;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_IDLE;
      a_held_q     <= 1'b0;
      d_held_q     <= 1'b0;
      la_held_q    <= 1'b0;
      ra_held_q    <= 1'b0;
      sp_held_q    <= 1'b0;
      p_held_q     <= 1'b0;
      pause_st_q   <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      fire_q       <= 1'b0;
      pause_q      <= 1'b0;
      cd_q         <= '0;
    end else begin
      state_q      <= state_d;
      a_held_q     <= a_held_d;
      d_held_q     <= d_held_d;
      la_held_q    <= la_held_d;
      ra_held_q    <= ra_held_d;
      sp_held_q    <= sp_held_d;
      p_held_q     <= p_held_d;
      pause_st_q   <= pause_st_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      fire_q       <= fire_d;
      pause_q      <= pause_d;
      cd_q         <= cd_d;
    end
  end

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.fire       = fire_q;
  assign bus.pause      = pause_q;
endmodule

// File: doc/ps2_game_input.md
Name: ps2_game_input

Overview:
- Translates decoded PS/2 keyboard bytes into the game-control levels consumed by the VGA game renderer: move_left, move_right, fire and pause.
- Sits between the PS/2 byte receiver and the renderer. Runs entirely in the iVGA_CLK domain.
- Tracks make/break/extended scan-code sequences and keeps a held-state for each mapped key.
- Produces a rate-limited fire pulse and a toggling pause level.

Parameters:
- FIRE_COOLDOWN, 2500000, cycles between successive fire pulses while space is held (0.1 s at 25 MHz).
- CNT_W, 22, width of the cooldown counter; must hold FIRE_COOLDOWN.

Ports:
- iVGA_CLK  input  1  system/pixel clock.
- iRST_n  input  1  reset.
- ps2_data  input  8  received scan-code byte, valid only when ps2_valid=1.
- ps2_valid  input  1  single-cycle strobe per received byte, synchronous to iVGA_CLK.
- move_left  output  1  level; high while a left key is held.
- move_right  output  1  level; high while a right key is held.
- fire  output  1  one-cycle pulse per shot.
- pause  output  1  level; toggled by each fresh P press.

Behaviour:
- Interface: reset iRST_n, asynchronous, active-low; clock iVGA_CLK.
- Reset: all outputs 0, all held flags 0, FSM in S_IDLE, cooldown 0.
- Key map, non-extended: 0x1C (A) = left, 0x23 (D) = right, 0x29 (space) = fire, 0x4D (P) = pause.
- Key map, extended (E0-prefixed): 0x6B = left arrow, 0x74 = right arrow.
- Any other code is ignored, but it still completes its sequence and returns the FSM to S_IDLE.
- FSM advances only on cycles with ps2_valid=1:
  - S_IDLE: E0 -> S_EXT; F0 -> S_BRK; else make(code, ext=0), stay S_IDLE.
  - S_EXT: F0 -> S_EXT_BRK; E0 -> stay S_EXT; else make(code, ext=1) -> S_IDLE.
  - S_BRK: E0 -> S_EXT_BRK; F0 -> stay S_BRK; else break(code, ext=0) -> S_IDLE.
  - S_EXT_BRK: E0/F0 -> stay; else break(code, ext=1) -> S_IDLE.
- Five held flags: a_held, d_held, la_held, ra_held, sp_held, plus p_held.
  - A make sets its flag; the matching break clears it.
  - A break with no prior make is harmless.
  - Flags update at the clock edge that samples the byte (edge k).
- Pause:
  - On a P make with p_held=0, the pause state toggles at edge k.
  - Typematic repeats (P make while p_held=1) do not toggle.
  - A P break clears p_held.
- Registered outputs, updated at edge k+1:
  - L = a_held|la_held; R = d_held|ra_held.
  - move_left = L & ~R & ~pause; move_right = R & ~L & ~pause.
  - When both directions are held, both outputs are 0.
  - pause output = pause state (visible at edge k+1).
- Fire and cooldown:
  - Cooldown counts down by 1 per cycle when nonzero, regardless of pause.
  - When sp_held=1 & cooldown==0 & pause state=0: fire=1 for exactly one cycle and cooldown loads FIRE_COOLDOWN in the same cycle.
  - Fire period while space is held = FIRE_COOLDOWN+1 cycles.
  - First pulse appears at edge k+1 after the space make, if cooldown is 0.
  - Releasing space does not clear cooldown: re-press spam cannot exceed the rate.
- Pause entry: pause=1 suppresses fire and forces both move outputs to 0. Held flags keep tracking, so moves resume immediately on unpause if keys are still held.
- Back-to-back ps2_valid on consecutive cycles: each is processed as an independent byte.
- Asynchronous reset mid-sequence (e.g. after E0): returns to S_IDLE and clears everything, including pause.

Test Plan:
- Reset, then bytes 1C; idle 3 cycles; then F0,1C -> move_left=1 from edge after 1C sampled +1; move_left=0 one cycle after the break's 1C byte; move_right stays 0.
- E0,74 then 23 then E0,F0,74 -> move_right=1 throughout; still 1 after the arrow break (D held); F0,23 -> 0.
- A held, then D make -> both moves 0; D break -> move_left returns to 1 one cycle later.
- FIRE_COOLDOWN=10: space make, hold 40 cycles -> fire pulses at cycles k+1, k+12, k+23, k+34, each exactly 1 cycle wide; space break then immediate re-make 2 cycles after a pulse -> no pulse until cooldown expires.
- P make, P make (typematic), P break -> pause=1 once (not toggled back). While A and space are held: move_left=0 and fire=0. Second P make/break -> pause=0 and move_left=1 within 1 cycle.
- Assert iRST_n=0 after E0 with no clock edge -> all outputs 0 immediately. After release, byte 6B alone -> no move (treated non-extended, unmapped).
